// File: rtl/seq_restoring_divider.sv
// Purpose: multi-cycle restoring divider, one quotient bit per clock (shift-and-subtract).
// Latency: done pulses WIDTH edges after the accepting start edge; divide-by-zero answers on the accepting edge.
// Backpressure: none; start is ignored while busy, results hold until the next accepted start.
// Optional: define SIGNED_DIV_EN for two's-complement operands (magnitude core plus sign fix-up).
module seq_restoring_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH:0]   part_q;   // partial remainder, always < divisor between steps
  logic [WIDTH-1:0] quo_q;    // dividend bits shift out the top, quotient bits shift in the bottom
  logic [WIDTH-1:0] dsr_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;
  logic             trial_ok;
  logic [WIDTH:0]   next_part;
  logic [WIDTH-1:0] next_quo;
  logic [WIDTH-1:0] fin_quo;
  logic [WIDTH-1:0] fin_rem;

  // One restoring step: the shifted partial never exceeds WIDTH+1 bits, so the extra top bit is a clean borrow flag.
  assign shifted   = {part_q, quo_q[WIDTH-1]};
  assign trial     = shifted - {2'b00, dsr_q};
  assign trial_ok  = ~trial[WIDTH+1];
  assign next_part = trial_ok ? trial[WIDTH:0] : shifted[WIDTH:0];
  assign next_quo  = {quo_q[WIDTH-2:0], trial_ok};

`ifdef SIGNED_DIV_EN
  logic quo_neg_q;
  logic rem_neg_q;

  // Core works on magnitudes; most-negative stays as its own unsigned magnitude, which also covers min / -1.
  assign a_mag   = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
  assign b_mag   = divisor[WIDTH-1]  ? (~divisor + 1'b1)  : divisor;
  assign fin_quo = quo_neg_q ? (~next_quo + 1'b1) : next_quo;
  assign fin_rem = rem_neg_q ? (~next_part[WIDTH-1:0] + 1'b1) : next_part[WIDTH-1:0];

  // Sign bookkeeping captured alongside the operands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
    end else if (start && (state != RUN)) begin
      quo_neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      rem_neg_q <= dividend[WIDTH-1];
    end
  end
`else
  assign a_mag   = dividend;
  assign b_mag   = divisor;
  assign fin_quo = next_quo;
  assign fin_rem = next_part[WIDTH-1:0];
`endif

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      part_q      <= '0;
      quo_q       <= '0;
      dsr_q       <= '0;
      cnt_q       <= '0;
    end else begin
      case (state)
        IDLE, FINISH: begin
          done <= 1'b0;
          if (start) begin
            if (divisor == '0) begin
              // Answered immediately; no iteration, busy never rises.
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              state       <= FINISH;
            end else begin
              div_by_zero <= 1'b0;
              part_q      <= '0;
              quo_q       <= a_mag;
              dsr_q       <= b_mag;
              cnt_q       <= CW'(WIDTH - 1);
              busy        <= 1'b1;
              state       <= RUN;
            end
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          part_q <= next_part;
          quo_q  <= next_quo;
          cnt_q  <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            quotient  <= fin_quo;
            remainder <= fin_rem;
            done      <= 1'b1;
            busy      <= 1'b0;
            state     <= FINISH;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
